// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the fetch stage and the control unit that consumes its output:
// MIPS opcode/funct fields, fetch FSM encoding and the default reset vector.
package instruction_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [1:0] ST_REQ  = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [1:0] ST_DROP = 2'd3;

   typedef enum logic [1:0] {
      REDIR_NONE = 2'd0,
      REDIR_BR   = 2'd1,
      REDIR_JR   = 2'd2,
      REDIR_JUMP = 2'd3
   } redir_src_e;

endpackage

// File: rtl/next_pc_mux.sv
// Redirect arbitration for the fetch stage: EX branch beats ID jr beats ID j/jal.
// Purely combinational; the selected target is always returned word-aligned.
module next_pc_mux
   import instruction_fetch_pkg::*;
(
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic [3:0]  pc4_hi,
   output logic        redir_valid,
   output logic [31:0] redir_target
);

   redir_src_e  src;
   logic [31:0] raw_target;

   always_comb begin
      src        = REDIR_NONE;
      raw_target = 32'h0;
      if (br_taken) begin
         src        = REDIR_BR;
         raw_target = br_target;
      end else if (jr) begin
         src        = REDIR_JR;
         raw_target = jr_target;
      end else if (jump) begin
         src        = REDIR_JUMP;
         raw_target = {pc4_hi, jump_index, 2'b00};
      end
   end

   assign redir_valid  = (src != REDIR_NONE);
   assign redir_target = raw_target & 32'hFFFF_FFFC;

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch with an IF/ID slot and one-entry skid buffer.
//   state | meaning
//   REQ   | drive imem_req with pc, wait for imem_ready
//   WAIT  | request accepted, waiting for imem_rvalid
//   HOLD  | returned word parked in skid while ID stalls
//   DROP  | redirected with a response in flight; swallow it
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc4,
   input  logic        id_stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic        jump,
   input  logic [25:0] jump_index
);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic [31:0] id_pc4_q, id_pc4_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc4_q, skid_pc4_d;

   logic        redir_valid;
   logic [31:0] redir_target;
   logic [31:0] pc_plus4;
   logic        slot_free;

   next_pc_mux u_next_pc_mux (
      .br_taken     (br_taken),
      .br_target    (br_target),
      .jr           (jr),
      .jr_target    (jr_target),
      .jump         (jump),
      .jump_index   (jump_index),
      .pc4_hi       (id_pc4_q[31:28]),
      .redir_valid  (redir_valid),
      .redir_target (redir_target)
   );

   assign pc_plus4  = pc_q + 32'd4;
   assign slot_free = !id_valid_q || !id_stall;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      id_valid_d   = id_valid_q;
      id_instr_d   = id_instr_q;
      id_pc4_d     = id_pc4_q;
      skid_instr_d = skid_instr_q;
      skid_pc4_d   = skid_pc4_q;

      if (id_valid_q && !id_stall)
         id_valid_d = 1'b0;

      if (redir_valid) begin
         pc_d       = redir_target;
         id_valid_d = 1'b0;
         // A request still owed by memory must be drained before refetching.
         case (state_q)
            ST_REQ:  state_d = imem_ready  ? ST_DROP : ST_REQ;
            ST_WAIT: state_d = imem_rvalid ? ST_REQ  : ST_DROP;
            ST_DROP: state_d = imem_rvalid ? ST_REQ  : ST_DROP;
            default: state_d = ST_REQ;
         endcase
      end else begin
         case (state_q)
            ST_REQ: begin
               if (imem_ready)
                  state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  pc_d = pc_plus4;
                  if (slot_free) begin
                     id_valid_d = 1'b1;
                     id_instr_d = imem_rdata;
                     id_pc4_d   = pc_plus4;
                     state_d    = ST_REQ;
                  end else begin
                     skid_instr_d = imem_rdata;
                     skid_pc4_d   = pc_plus4;
                     state_d      = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (!id_stall) begin
                  id_valid_d = 1'b1;
                  id_instr_d = skid_instr_q;
                  id_pc4_d   = skid_pc4_q;
                  state_d    = ST_REQ;
               end
            end
            ST_DROP: begin
               if (imem_rvalid)
                  state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_REQ;
         pc_q         <= RESET_PC;
         id_valid_q   <= 1'b0;
         id_instr_q   <= 32'h0;
         id_pc4_q     <= 32'h0;
         skid_instr_q <= 32'h0;
         skid_pc4_q   <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         id_valid_q   <= id_valid_d;
         id_instr_q   <= id_instr_d;
         id_pc4_q     <= id_pc4_d;
         skid_instr_q <= skid_instr_d;
         skid_pc4_q   <= skid_pc4_d;
      end
   end

   // Gated by rst_n so the request drops the instant reset asserts.
   assign imem_req  = rst_n && (state_q == ST_REQ);
   assign imem_addr = pc_q;
   assign id_valid  = id_valid_q;
   assign id_instr  = id_instr_q;
   assign id_pc4    = id_pc4_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: inputs change and outputs are sampled on the
// falling edge; expected values are hand-computed per scenario.
module tb_instruction_fetch;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc4;
   logic        id_stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jr;
   logic [31:0] jr_target;
   logic        jump;
   logic [25:0] jump_index;

   int total;
   int bad;

   instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .id_valid    (id_valid),
      .id_instr    (id_instr),
      .id_pc4      (id_pc4),
      .id_stall    (id_stall),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .jr          (jr),
      .jr_target   (jr_target),
      .jump        (jump),
      .jump_index  (jump_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Zero-wait memory: accept in REQ, return data on the following cycle.
   task automatic fetch_word(input logic [31:0] data);
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready  = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      @(negedge clk);
      imem_rvalid = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", id_valid); end
      total++; if (id_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", id_instr); end
      total++; if (id_pc4 !== 32'h0) begin bad++; $display("FAIL reset_pc4 got=%h exp=0", id_pc4); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL release_req got=%0b exp=1", imem_req); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL release_addr got=%h exp=0", imem_addr); end
   endtask

   task automatic test_fetch;
      fetch_word(32'h2008_0005);
      total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL fetch_valid got=%0b exp=1", id_valid); end
      total++; if (id_instr !== 32'h2008_0005) begin bad++; $display("FAIL fetch_instr got=%h exp=20080005", id_instr); end
      total++; if (id_pc4 !== 32'h4) begin bad++; $display("FAIL fetch_pc4 got=%h exp=4", id_pc4); end
      total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL fetch_next_addr got=%h exp=4", imem_addr); end
   endtask

   task automatic test_stall;
      id_stall   = 1'b1;
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready  = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0000_0020;
      total++; if (id_instr !== 32'h2008_0005) begin bad++; $display("FAIL stall_c1_instr got=%h exp=20080005", id_instr); end
      @(negedge clk);
      imem_rvalid = 1'b0;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_hold_req got=%0b exp=0", imem_req); end
      total++; if (id_instr !== 32'h2008_0005) begin bad++; $display("FAIL stall_c2_instr got=%h exp=20080005", id_instr); end
      @(negedge clk);
      total++; if (id_instr !== 32'h2008_0005) begin bad++; $display("FAIL stall_c3_instr got=%h exp=20080005", id_instr); end
      total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL stall_c3_valid got=%0b exp=1", id_valid); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_c3_req got=%0b exp=0", imem_req); end
      id_stall = 1'b0;
      @(negedge clk);
      total++; if (id_instr !== 32'h0000_0020) begin bad++; $display("FAIL skid_instr got=%h exp=20", id_instr); end
      total++; if (id_pc4 !== 32'h8) begin bad++; $display("FAIL skid_pc4 got=%h exp=8", id_pc4); end
      total++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin bad++; $display("FAIL skid_next got=%h/%0b exp=8/1", imem_addr, imem_req); end
   endtask

   task automatic test_slot_clear;
      @(negedge clk);
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL slot_clear got=%0b exp=0", id_valid); end
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL slot_clear_req got=%0b exp=1", imem_req); end
   endtask

   task automatic test_jump_drop;
      br_taken  = 1'b1;
      br_target = 32'h1000_0005;
      @(negedge clk);
      br_taken = 1'b0;
      total++; if (imem_addr !== 32'h1000_0004 || imem_req !== 1'b1) begin bad++; $display("FAIL br_align got=%h/%0b exp=10000004/1", imem_addr, imem_req); end
      fetch_word(32'hDEAD_0001);
      total++; if (id_pc4 !== 32'h1000_0008) begin bad++; $display("FAIL jd_pc4 got=%h exp=10000008", id_pc4); end
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      jump       = 1'b1;
      jump_index = 26'h000_0040;
      @(negedge clk);
      jump = 1'b0;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL drop_req got=%0b exp=0", imem_req); end
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_BAD0;
      @(negedge clk);
      imem_rvalid = 1'b0;
      total++; if (imem_addr !== 32'h1000_0100 || imem_req !== 1'b1) begin bad++; $display("FAIL jump_addr got=%h/%0b exp=10000100/1", imem_addr, imem_req); end
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL drop_valid got=%0b exp=0", id_valid); end
      total++; if (id_instr !== 32'hDEAD_0001) begin bad++; $display("FAIL drop_instr got=%h exp=dead0001", id_instr); end
   endtask

   task automatic test_priority;
      fetch_word(32'h1111_2222);
      id_stall   = 1'b1;
      br_taken   = 1'b1;
      br_target  = 32'h0000_0200;
      jr         = 1'b1;
      jr_target  = 32'h0000_0300;
      jump       = 1'b1;
      jump_index = 26'h3FF_FFFF;
      @(negedge clk);
      br_taken = 1'b0;
      total++; if (imem_addr !== 32'h0000_0200) begin bad++; $display("FAIL prio_br got=%h exp=200", imem_addr); end
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL prio_valid got=%0b exp=0", id_valid); end
      jr_target  = 32'h0000_0303;
      imem_ready = 1'b1;
      @(negedge clk);
      jr         = 1'b0;
      jump       = 1'b0;
      imem_ready = 1'b0;
      id_stall   = 1'b0;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL req_ready_drop got=%0b exp=0", imem_req); end
      imem_rvalid = 1'b1;
      @(negedge clk);
      imem_rvalid = 1'b0;
      total++; if (imem_addr !== 32'h0000_0300 || imem_req !== 1'b1) begin bad++; $display("FAIL prio_jr got=%h/%0b exp=300/1", imem_addr, imem_req); end
   endtask

   task automatic test_wrap;
      br_taken  = 1'b1;
      br_target = 32'hFFFF_FFFC;
      @(negedge clk);
      br_taken = 1'b0;
      total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_start got=%h exp=fffffffc", imem_addr); end
      fetch_word(32'hCAFE_0000);
      total++; if (id_instr !== 32'hCAFE_0000) begin bad++; $display("FAIL wrap_instr got=%h exp=cafe0000", id_instr); end
      total++; if (id_pc4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h exp=0", id_pc4); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] exp_pc4;
      logic [31:0] word;
      for (int i = 0; i < 3; i++) begin
         exp_pc4 = 32'(4 * (i + 1));
         word    = 32'h0000_0100 + 32'(i);
         fetch_word(word);
         total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%0b exp=1", i, id_valid); end
         total++; if (id_instr !== word || id_pc4 !== exp_pc4) begin bad++; $display("FAIL b2b_data[%0d] got=%h/%h exp=%h/%h", i, id_instr, id_pc4, word, exp_pc4); end
      end
   endtask

   task automatic test_async_reset;
      id_stall   = 1'b1;
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      total++; if (id_valid !== 1'b1 || id_instr !== 32'h0000_0102) begin bad++; $display("FAIL pre_reset got=%0b/%h exp=1/102", id_valid, id_instr); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%0b exp=0", id_valid); end
      total++; if (id_instr !== 32'h0 || id_pc4 !== 32'h0) begin bad++; $display("FAIL arst_data got=%h/%h exp=0/0", id_instr, id_pc4); end
      total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin bad++; $display("FAIL arst_req got=%0b/%h exp=0/0", imem_req, imem_addr); end
      @(negedge clk);
      id_stall = 1'b0;
      rst_n    = 1'b1;
      #1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL restart_req got=%0b/%h exp=1/0", imem_req, imem_addr); end
      fetch_word(32'h2008_0005);
      total++; if (id_instr !== 32'h2008_0005 || id_pc4 !== 32'h4) begin bad++; $display("FAIL restart_fetch got=%h/%h exp=20080005/4", id_instr, id_pc4); end
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      rst_n       = 1'b0;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      id_stall    = 1'b0;
      br_taken    = 1'b0;
      br_target   = 32'h0;
      jr          = 1'b0;
      jr_target   = 32'h0;
      jump        = 1'b0;
      jump_index  = 26'h0;
      test_reset();
      test_fetch();
      test_stall();
      test_slot_clear();
      test_jump_drop();
      test_priority();
      test_wrap();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port imem_req  output  1  SHALL be the instruction-memory request valid.
REQ-005 Port imem_addr  output  32  SHALL be the word-aligned fetch address, valid while imem_req=1.
REQ-006 Port imem_ready  input  1  SHALL indicate request accepted this cycle.
REQ-007 Port imem_rvalid  input  1  SHALL indicate imem_rdata valid, at most one outstanding request.
REQ-008 Port imem_rdata  input  32  SHALL be the returned instruction word.
REQ-009 Port id_valid  output  1  SHALL be the IF/ID slot valid flag.
REQ-010 Port id_instr  output  32  SHALL be the instruction presented to the control unit.
REQ-011 Port id_pc4  output  32  SHALL be the fetch address + 4 of id_instr.
REQ-012 Port id_stall  input  1  SHALL hold the IF/ID slot when asserted with id_valid=1.
REQ-013 Port br_taken/br_target  input  1/32  SHALL be the EX-stage taken branch and its target.
REQ-014 Port jr/jr_target  input  1/32  SHALL be the ID-stage jump-register redirect and target.
REQ-015 Port jump/jump_index  input  1/26  SHALL be the ID-stage j/jal redirect; target {id_pc4[31:28], jump_index, 2'b00}.

Function
REQ-016 States SHALL be REQ, WAIT, HOLD, DROP; reset state REQ.
REQ-017 REQ: imem_req=1, imem_addr=pc; imem_ready=1 -> WAIT.
REQ-018 WAIT: imem_rvalid=1 and slot free (id_valid=0 or id_stall=0) -> load id_instr=rdata, id_pc4=pc+4, id_valid=1, pc<=pc+4, -> REQ.
REQ-019 WAIT: imem_rvalid=1 with id_valid=1 and id_stall=1 -> capture into one-entry skid buffer, pc<=pc+4, -> HOLD.
REQ-020 HOLD: imem_req=0; id_stall=0 -> move skid into IF/ID, -> REQ.
REQ-021 IF/ID slot with id_stall=0 and no new instruction SHALL clear id_valid next cycle.
REQ-022 Redirect priority SHALL be br_taken > jr > jump; ignored when no redirect input asserted.
REQ-023 Redirect in any state SHALL set pc<=target with bits[1:0] forced 00, clear id_valid, discard skid, override id_stall.
REQ-024 Redirect in WAIT without rvalid, or in REQ with imem_ready=1, -> DROP; otherwise -> REQ.
REQ-025 DROP: imem_req=0; imem_rvalid=1 -> discard data, -> REQ; further redirects in DROP update pc only.
REQ-026 pc arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0.
REQ-027 Fetch latency SHALL be 1 cycle from imem_rvalid to id_valid; back-to-back fetch with zero-wait memory yields one instruction per 2 cycles.

Reset
REQ-028 rst_n=0 SHALL immediately force pc=RESET_PC, state=REQ, id_valid=0, id_instr=0, id_pc4=0, skid empty, imem_req=0.
REQ-029 First imem_req=1 SHALL occur in the first cycle after rst_n deasserts; a response outstanding at reset SHALL be dropped by the memory, not tracked.

Structure
REQ-030 Shared package SHALL hold the opcode/funct constants used by the control unit, the fetch state encoding, and the RESET_PC default.
REQ-031 One combinational sub-module next_pc_mux SHALL implement redirect priority and target formation; all state stays in instruction_fetch.

Verification
REQ-032 Reset release, zero-wait memory returning 32'h2008_0005 -> imem_addr=0, then id_valid=1, id_instr=32'h2008_0005, id_pc4=4.
REQ-033 id_stall held 3 cycles while next word 32'h0000_0020 returns -> HOLD entered, id_instr unchanged for 3 cycles, then 32'h0000_0020 with id_pc4=8.
REQ-034 jump=1, jump_index=26'h000_0040, id_pc4=32'h1000_0008 during WAIT without rvalid -> DROP, stale rdata discarded, next imem_addr=32'h1000_0100.
REQ-035 br_taken=1 target 32'h0000_0200 and jr=1 target 32'h0000_0300 same cycle -> next imem_addr=32'h0000_0200, id_valid=0.
REQ-036 pc=32'hFFFF_FFFC fetch completes -> next imem_addr=32'h0000_0000.
REQ-037 rst_n asserted mid-WAIT -> outputs return to reset values without clk edge; fetch restarts at RESET_PC.
